// File: rtl/cont_pkg.sv
// Shared definitions for the bouncing 4-bit counter and its sweep monitor.
package cont_pkg;

  localparam int         CNT_W   = 4;
  localparam logic [3:0] CNT_MAX = 4'd15;

  typedef enum logic [2:0] {
    START = 3'd0,
    UP    = 3'd1,
    TOP   = 3'd2,
    DOWN  = 3'd3,
    BOT   = 3'd4,
    ERR   = 3'd5
  } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, clears on rst.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/cont_sweep_monitor.sv
// Checks the 0..MAX,MAX..0,0 sweep of the bouncing counter; all outputs registered (latency 1).
// Optional MON_RESYNC_EN: ERR returns to START on a sampled 0 (err_o stays sticky).
module cont_sweep_monitor
  import cont_pkg::*;
#(
  parameter int WIDTH   = CNT_W,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   s_in,
  output logic               dir_o,
  output logic               peak_o,
  output logic               trough_o,
  output logic [SWEEP_W-1:0] sweep_cnt_o,
  output logic               lock_o,
  output logic               err_o
);

  localparam logic [WIDTH:0] MAX_X = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  mon_state_t       state, state_n;
  logic [WIDTH-1:0] prev;
  logic [WIDTH:0]   s_x, prev_x;
  logic             up_ok, dn_ok, at_max, at_zero;
  logic             dir_n, peak_n, trough_n, inc;

  // One extra bit so prev+1 at MAX and prev-1 at 0 can never match a legal sample.
  assign s_x     = {1'b0, s_in};
  assign prev_x  = {1'b0, prev};
  assign up_ok   = (s_x == prev_x + ONE_X);
  assign dn_ok   = (s_x == prev_x - ONE_X);
  assign at_max  = (s_x == MAX_X);
  assign at_zero = (s_x == '0);

  always_comb begin
    state_n  = state;
    dir_n    = dir_o;
    peak_n   = 1'b0;
    trough_n = 1'b0;
    inc      = 1'b0;
    case (state)
      START: begin
        if (at_zero) begin
          state_n = START;
        end else if (s_x == ONE_X) begin
          state_n = UP;
          dir_n   = 1'b0;
        end else begin
          state_n = ERR;
        end
      end
      UP: begin
        if (!up_ok) begin
          state_n = ERR;
        end else if (at_max) begin
          state_n = TOP;
          peak_n  = 1'b1;
        end
      end
      TOP: begin
        if (at_max) begin
          state_n = DOWN;
          dir_n   = 1'b1;
        end else begin
          state_n = ERR;
        end
      end
      DOWN: begin
        if (!dn_ok) begin
          state_n = ERR;
        end else if (at_zero) begin
          state_n  = BOT;
          trough_n = 1'b1;
        end
      end
      BOT: begin
        if (at_zero) begin
          state_n = UP;
          dir_n   = 1'b0;
          inc     = 1'b1;
        end else begin
          state_n = ERR;
        end
      end
      ERR: begin
`ifdef MON_RESYNC_EN
        if (at_zero) state_n = START;
`endif
      end
      default: state_n = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= START;
      prev     <= '0;
      dir_o    <= 1'b0;
      peak_o   <= 1'b0;
      trough_o <= 1'b0;
      lock_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_n;
      prev     <= s_in;
      dir_o    <= dir_n;
      peak_o   <= peak_n;
      trough_o <= trough_n;
      lock_o   <= (state_n == UP) || (state_n == TOP) ||
                  (state_n == DOWN) || (state_n == BOT);
      err_o    <= err_o | (state_n == ERR);
    end
  end

  sat_counter #(.W(SWEEP_W)) u_sweep_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc),
    .cnt (sweep_cnt_o)
  );

endmodule
